enc_counter_bank: RTL and testbench

ENC_COUNTER_BANK -- requirements
Module: enc_counter_bank

---
 rtl/enc_counter_pkg.sv | 18 +
 rtl/enc_counter_bank_if.sv | 29 ++
 rtl/enc_counter_chan.sv | 57 +++++
 rtl/enc_counter_bank.sv | 91 +++++++++
 tb/tb_enc_counter_bank.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/enc_counter_pkg.sv
// Shared types and helpers for the encoder counter bank: snapshot FSM state
// and the signed range limits of a BITS-wide two's complement counter.
package enc_counter_pkg;

   typedef enum logic {
      SNAP_IDLE = 1'b0,
      SNAP_ACK  = 1'b1
   } snap_state_t;

   function automatic logic [31:0] signed_max(input int bits);
      return (32'd1 << (bits - 1)) - 32'd1;
   endfunction

   function automatic logic [31:0] signed_min(input int bits);
      return 32'd1 << (bits - 1);
   endfunction

endpackage

// File: rtl/enc_counter_bank_if.sv
// Count-request, snapshot-readout and flag signals of the encoder counter bank.
// The master side (controller) drives requests; the slave side is the bank.
interface enc_counter_bank_if #(
   parameter int CHANNELS = 4,
   parameter int BITS     = 16,
   parameter int SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
   logic [CHANNELS-1:0] up;
   logic [CHANNELS-1:0] down;
   logic [CHANNELS-1:0] clear;
   logic                snap_req;
   logic                snap_ack;
   logic [SELW-1:0]     sel;
   logic [BITS-1:0]     rd_count;
   logic [BITS-1:0]     rd_delta;
   logic [CHANNELS-1:0] ovf;
   logic [CHANNELS-1:0] err;
   logic                flag_clr;

   modport master (
      output up, down, clear, snap_req, sel, flag_clr,
      input  snap_ack, rd_count, rd_delta, ovf, err
   );

   modport slave (
      input  up, down, clear, snap_req, sel, flag_clr,
      output snap_ack, rd_count, rd_delta, ovf, err
   );
endinterface

// File: rtl/enc_counter_chan.sv
// One up/down counter channel with sticky overflow and up+down conflict flags.
// Wraps or clamps at the signed limits depending on SATURATE.
module enc_counter_chan
   import enc_counter_pkg::*;
#(
   parameter int BITS     = 16,
   parameter int SATURATE = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            up,
   input  logic            down,
   input  logic            clear,
   input  logic            flag_clr,
   output logic [BITS-1:0] count,
   output logic            ovf,
   output logic            err
);

   localparam logic [BITS-1:0] MAXV = BITS'(signed_max(BITS));
   localparam logic [BITS-1:0] MINV = BITS'(signed_min(BITS));
   localparam bit              SAT  = (SATURATE != 0);

   logic step_up;
   logic step_dn;
   logic at_max;
   logic at_min;
   logic ovf_ev;
   logic err_ev;

   assign step_up = up & ~down;
   assign step_dn = down & ~up;
   assign at_max  = (count == MAXV);
   assign at_min  = (count == MINV);
   assign ovf_ev  = ~clear & ((step_up & at_max) | (step_dn & at_min));
   assign err_ev  = up & down;

   // A new flag event in the same cycle as flag_clr keeps the bit set.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         ovf   <= 1'b0;
         err   <= 1'b0;
      end else begin
         if (clear) begin
            count <= '0;
         end else if (step_up && !(SAT && at_max)) begin
            count <= count + 1'b1;
         end else if (step_dn && !(SAT && at_min)) begin
            count <= count - 1'b1;
         end
         ovf <= ovf_ev | (ovf & ~flag_clr);
         err <= err_ev | (err & ~flag_clr);
      end
   end

endmodule

// File: rtl/enc_counter_bank.sv
// Bank of CHANNELS encoder counters with a shared snapshot/acknowledge FSM and
// a sel-indexed readout of the captured counts and their snapshot-to-snapshot delta.
module enc_counter_bank
   import enc_counter_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int BITS     = 16,
   parameter int SATURATE = 0
) (
   input logic               clk,
   input logic               rst,
   enc_counter_bank_if.slave bus
);

   logic [BITS-1:0]     count [CHANNELS];
   logic [BITS-1:0]     snap  [CHANNELS];
   logic [BITS-1:0]     delta [CHANNELS];
   logic [CHANNELS-1:0] ovf_v;
   logic [CHANNELS-1:0] err_v;
   logic [BITS-1:0]     rd_count;
   logic [BITS-1:0]     rd_delta;
   logic                snap_ack;
   snap_state_t         state;

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : gen_ch
      enc_counter_chan #(
         .BITS     (BITS),
         .SATURATE (SATURATE)
      ) u_chan (
         .clk      (clk),
         .rst      (rst),
         .up       (bus.up[gi]),
         .down     (bus.down[gi]),
         .clear    (bus.clear[gi]),
         .flag_clr (bus.flag_clr),
         .count    (count[gi]),
         .ovf      (ovf_v[gi]),
         .err      (err_v[gi])
      );
   end

   // Capture samples the counters before this edge's step; requests seen in
   // ACK are dropped, so a held request re-captures every other cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= SNAP_IDLE;
         snap_ack <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) begin
            snap[i]  <= '0;
            delta[i] <= '0;
         end
      end else begin
         case (state)
            SNAP_IDLE: begin
               snap_ack <= 1'b0;
               if (bus.snap_req) begin
                  for (int i = 0; i < CHANNELS; i++) begin
                     snap[i]  <= count[i];
                     delta[i] <= count[i] - snap[i];
                  end
                  state    <= SNAP_ACK;
                  snap_ack <= 1'b1;
               end
            end
            SNAP_ACK: begin
               state    <= SNAP_IDLE;
               snap_ack <= 1'b0;
            end
         endcase
      end
   end

   // Out-of-range selects match no channel and read back as zero.
   always_comb begin
      rd_count = '0;
      rd_delta = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (int'(bus.sel) == i) begin
            rd_count = snap[i];
            rd_delta = delta[i];
         end
      end
   end

   assign bus.rd_count = rd_count;
   assign bus.rd_delta = rd_delta;
   assign bus.snap_ack = snap_ack;
   assign bus.ovf      = ovf_v;
   assign bus.err      = err_v;

endmodule

// File: tb/tb_enc_counter_bank.sv
// Testbench for enc_counter_bank: a wrapping 3-channel and a saturating 4-channel
// 8-bit bank share one stimulus stream and are checked against a behavioural model.
module tb_enc_counter_bank;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] up;
   logic [3:0] down;
   logic [3:0] clear;
   logic       snap_req;
   logic       flag_clr;
   logic [1:0] sel;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   enc_counter_bank_if #(.CHANNELS(3), .BITS(8)) ifw ();
   enc_counter_bank_if #(.CHANNELS(4), .BITS(8)) ifs ();

   assign ifw.up       = up[2:0];
   assign ifw.down     = down[2:0];
   assign ifw.clear    = clear[2:0];
   assign ifw.snap_req = snap_req;
   assign ifw.flag_clr = flag_clr;
   assign ifw.sel      = sel;
   assign ifs.up       = up;
   assign ifs.down     = down;
   assign ifs.clear    = clear;
   assign ifs.snap_req = snap_req;
   assign ifs.flag_clr = flag_clr;
   assign ifs.sel      = sel;

   enc_counter_bank #(.CHANNELS(3), .BITS(8), .SATURATE(0)) dut_w (
      .clk (clk),
      .rst (rst),
      .bus (ifw.slave)
   );

   enc_counter_bank #(.CHANNELS(4), .BITS(8), .SATURATE(1)) dut_s (
      .clk (clk),
      .rst (rst),
      .bus (ifs.slave)
   );

   // Behavioural model: index 0 is the wrapping bank, index 1 the saturating one.
   // Counts are kept as signed integers in -128..127.
   int nch [2]  = '{3, 4};
   bit satm [2] = '{1'b0, 1'b1};
   int m_cnt   [2][4];
   int m_snap  [2][4];
   int m_delta [2][4];
   bit m_ovf   [2][4];
   bit m_err   [2][4];
   bit m_ack   [2];

   task automatic model_step();
      int  s;
      int  newv;
      bit  ev;
      if (rst) begin
         for (int d = 0; d < 2; d++) begin
            m_ack[d] = 1'b0;
            for (int c = 0; c < 4; c++) begin
               m_cnt[d][c] = 0; m_snap[d][c] = 0; m_delta[d][c] = 0;
               m_ovf[d][c] = 1'b0; m_err[d][c] = 1'b0;
            end
         end
         return;
      end
      for (int d = 0; d < 2; d++) begin
         if (!m_ack[d] && snap_req) begin
            for (int c = 0; c < nch[d]; c++) begin
               newv = m_cnt[d][c] & 255;
               m_delta[d][c] = (newv - m_snap[d][c]) & 255;
               m_snap[d][c]  = newv;
            end
         end
         m_ack[d] = !m_ack[d] && snap_req;
         for (int c = 0; c < nch[d]; c++) begin
            s  = m_cnt[d][c];
            ev = 1'b0;
            if (clear[c]) begin
               s = 0;
            end else if (up[c] && !down[c]) begin
               if (s == 127) begin ev = 1'b1; s = satm[d] ? 127 : -128; end
               else s = s + 1;
            end else if (down[c] && !up[c]) begin
               if (s == -128) begin ev = 1'b1; s = satm[d] ? -128 : 127; end
               else s = s - 1;
            end
            m_cnt[d][c] = s;
            m_ovf[d][c] = ev || (m_ovf[d][c] && !flag_clr);
            m_err[d][c] = (up[c] && down[c]) || (m_err[d][c] && !flag_clr);
         end
      end
   endtask

   function automatic logic [7:0] exp_rdc(int d);
      if (int'(sel) < nch[d]) return 8'(m_snap[d][sel]);
      return 8'h00;
   endfunction

   function automatic logic [7:0] exp_rdd(int d);
      if (int'(sel) < nch[d]) return 8'(m_delta[d][sel]);
      return 8'h00;
   endfunction

   function automatic logic [22:0] pack_w();
      logic [2:0] o, e;
      for (int c = 0; c < 3; c++) begin o[c] = m_ovf[0][c]; e[c] = m_err[0][c]; end
      return {m_ack[0], o, e, exp_rdc(0), exp_rdd(0)};
   endfunction

   function automatic logic [24:0] pack_s();
      logic [3:0] o, e;
      for (int c = 0; c < 4; c++) begin o[c] = m_ovf[1][c]; e[c] = m_err[1][c]; end
      return {m_ack[1], o, e, exp_rdc(1), exp_rdd(1)};
   endfunction

   // Inputs change after the falling edge; outputs are sampled on the next one.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      up = '0; down = '0; clear = '0; snap_req = 1'b0; flag_clr = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [22:0] ow;
      logic [24:0] os;
      up = 4'hF; down = 4'h0; clear = 4'h0; snap_req = 1'b1; flag_clr = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         #1;
         ow = {ifw.snap_ack, ifw.ovf, ifw.err, ifw.rd_count, ifw.rd_delta};
         os = {ifs.snap_ack, ifs.ovf, ifs.err, ifs.rd_count, ifs.rd_delta};
         checks++;
         if (ow !== 23'd0) begin
            failures++;
            $display("[TB] FAIL reset_w sel=%0d: got %h expected 0", s, ow);
         end
         checks++;
         if (os !== 25'd0) begin
            failures++;
            $display("[TB] FAIL reset_s sel=%0d: got %h expected 0", s, os);
         end
      end
      rst = 1'b0;
      idle_inputs();
   endtask

   task automatic test_wrap_count();
      do_reset();
      sel = 2'd0;
      for (int i = 1; i <= 130; i++) begin
         up = 4'b0001;
         tick();
         if (i == 127 || i == 128) begin
            checks++;
            if (ifw.ovf[0] !== (i == 128)) begin
               failures++;
               $display("[TB] FAIL wrap_ovf_step%0d: got %b expected %b", i, ifw.ovf[0], (i == 128));
            end
         end
         checks++;
         if ({ifw.snap_ack, ifw.ovf, ifw.err, ifw.rd_count, ifw.rd_delta} !== pack_w()) begin
            failures++;
            $display("[TB] FAIL wrap_cycle%0d: got %h expected %h", i,
                     {ifw.snap_ack, ifw.ovf, ifw.err, ifw.rd_count, ifw.rd_delta}, pack_w());
         end
      end
      up = '0; snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
      checks++;
      if ({ifw.snap_ack, ifw.rd_count} !== {1'b1, 8'h82}) begin
         failures++;
         $display("[TB] FAIL wrap_130: got ack=%b count=%h expected ack=1 count=82", ifw.snap_ack, ifw.rd_count);
      end
      checks++;
      if ({ifs.rd_count, ifs.ovf[0]} !== {8'h7F, 1'b1}) begin
         failures++;
         $display("[TB] FAIL sat_up_130: got count=%h ovf=%b expected count=7f ovf=1", ifs.rd_count, ifs.ovf[0]);
      end
      tick();
   endtask

   task automatic test_saturate_down();
      do_reset();
      sel = 2'd0;
      down = 4'b0001;
      repeat (200) tick();
      down = '0; snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
      checks++;
      if ({ifs.rd_count, ifs.ovf[0]} !== {8'h80, 1'b1}) begin
         failures++;
         $display("[TB] FAIL sat_down_200: got count=%h ovf=%b expected count=80 ovf=1", ifs.rd_count, ifs.ovf[0]);
      end
      checks++;
      if ({ifw.rd_count, ifw.ovf[0]} !== {8'h38, 1'b1}) begin
         failures++;
         $display("[TB] FAIL wrap_down_200: got count=%h ovf=%b expected count=38 ovf=1", ifw.rd_count, ifw.ovf[0]);
      end
      up = 4'b0001;
      tick();
      up = '0; snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
      checks++;
      if ({ifs.rd_count, ifs.rd_delta} !== {8'h81, 8'h01}) begin
         failures++;
         $display("[TB] FAIL sat_up_from_min: got count=%h delta=%h expected count=81 delta=01", ifs.rd_count, ifs.rd_delta);
      end
      tick();
   endtask

   task automatic test_err();
      do_reset();
      sel = 2'd2;
      up = 4'b0100;
      repeat (5) tick();
      up = 4'b0100; down = 4'b0100;
      repeat (3) tick();
      idle_inputs();
      checks++;
      if ({ifw.err, ifs.err} !== {3'b100, 4'b0100}) begin
         failures++;
         $display("[TB] FAIL err_set: got w=%b s=%b expected w=100 s=0100", ifw.err, ifs.err);
      end
      snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
      checks++;
      if ({ifw.rd_count, ifs.rd_count} !== {8'd5, 8'd5}) begin
         failures++;
         $display("[TB] FAIL err_hold: got w=%0d s=%0d expected 5", ifw.rd_count, ifs.rd_count);
      end
      flag_clr = 1'b1;
      tick();
      flag_clr = 1'b0;
      checks++;
      if ({ifw.err, ifs.err} !== 7'd0) begin
         failures++;
         $display("[TB] FAIL err_clear: got w=%b s=%b expected 0", ifw.err, ifs.err);
      end
   endtask

   task automatic test_snapshot_delta();
      do_reset();
      sel = 2'd1;
      up = 4'b0010;
      repeat (10) tick();
      up = '0; snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
      checks++;
      if ({ifw.snap_ack, ifw.rd_count, ifw.rd_delta} !== {1'b1, 8'd10, 8'd10}) begin
         failures++;
         $display("[TB] FAIL snap1: got ack=%b count=%0d delta=%0d expected 1/10/10", ifw.snap_ack, ifw.rd_count, ifw.rd_delta);
      end
      up = 4'b0010;
      tick();
      checks++;
      if (ifw.snap_ack !== 1'b0) begin
         failures++;
         $display("[TB] FAIL snap_ack_width: got %b expected 0", ifw.snap_ack);
      end
      repeat (2) tick();
      up = '0; snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
      checks++;
      if ({ifs.snap_ack, ifs.rd_count, ifs.rd_delta} !== {1'b1, 8'd13, 8'd3}) begin
         failures++;
         $display("[TB] FAIL snap2: got ack=%b count=%0d delta=%0d expected 1/13/3", ifs.snap_ack, ifs.rd_count, ifs.rd_delta);
      end
      tick();
   endtask

   task automatic test_snap_same_cycle();
      do_reset();
      sel = 2'd0;
      up = 4'b0001;
      repeat (7) tick();
      snap_req = 1'b1;
      tick();
      idle_inputs();
      checks++;
      if (ifw.rd_count !== 8'd7) begin
         failures++;
         $display("[TB] FAIL snap_pre_step: got %0d expected 7", ifw.rd_count);
      end
      tick();
      snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
      checks++;
      if ({ifs.rd_count, ifs.rd_delta} !== {8'd8, 8'd1}) begin
         failures++;
         $display("[TB] FAIL snap_post_step: got count=%0d delta=%0d expected 8/1", ifs.rd_count, ifs.rd_delta);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      do_reset();
      snap_req = 1'b1;
      for (int i = 0; i < 8; i++) begin
         up   = 4'($urandom);
         down = 4'($urandom) & ~up;
         sel  = 2'($urandom);
         tick();
         checks++;
         if (ifs.snap_ack !== (i % 2 == 0)) begin
            failures++;
            $display("[TB] FAIL b2b_ack%0d: got %b expected %b", i, ifs.snap_ack, (i % 2 == 0));
         end
         checks++;
         if ({ifs.snap_ack, ifs.ovf, ifs.err, ifs.rd_count, ifs.rd_delta} !== pack_s()) begin
            failures++;
            $display("[TB] FAIL b2b_s%0d: got %h expected %h", i,
                     {ifs.snap_ack, ifs.ovf, ifs.err, ifs.rd_count, ifs.rd_delta}, pack_s());
         end
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_reset_in_ack();
      do_reset();
      up = 4'hF;
      repeat (5) tick();
      up = '0; snap_req = 1'b1; sel = 2'd1;
      tick();
      checks++;
      if ({ifw.snap_ack, ifw.rd_count} !== {1'b1, 8'd5}) begin
         failures++;
         $display("[TB] FAIL pre_abort: got ack=%b count=%0d expected 1/5", ifw.snap_ack, ifw.rd_count);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0; snap_req = 1'b0;
      checks++;
      if ({ifw.snap_ack, ifw.ovf, ifw.err, ifw.rd_count, ifw.rd_delta, ifs.snap_ack, ifs.ovf, ifs.err,
           ifs.rd_count, ifs.rd_delta} !== 48'd0) begin
         failures++;
         $display("[TB] FAIL abort_zero: got w=%b/%h/%h s=%b/%h/%h expected all 0", ifw.snap_ack,
                  ifw.rd_count, ifw.rd_delta, ifs.snap_ack, ifs.rd_count, ifs.rd_delta);
      end
      tick();
      checks++;
      if ({ifw.snap_ack, ifs.snap_ack} !== 2'b00) begin
         failures++;
         $display("[TB] FAIL abort_no_pulse: got w=%b s=%b expected 0", ifw.snap_ack, ifs.snap_ack);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         up       = 4'($urandom) | 4'($urandom);
         down     = 4'($urandom) & 4'($urandom);
         clear    = (4'($urandom) & 4'($urandom) & 4'($urandom)) & ~(up & down);
         snap_req = ($urandom_range(0, 2) == 0);
         flag_clr = ($urandom_range(0, 7) == 0);
         sel      = 2'($urandom);
         rst      = ($urandom_range(0, 199) == 0);
         tick();
         checks++;
         if ({ifw.snap_ack, ifw.ovf, ifw.err, ifw.rd_count, ifw.rd_delta} !== pack_w()) begin
            failures++;
            $display("[TB] FAIL rand_w%0d: got %h expected %h", i,
                     {ifw.snap_ack, ifw.ovf, ifw.err, ifw.rd_count, ifw.rd_delta}, pack_w());
         end
         checks++;
         if ({ifs.snap_ack, ifs.ovf, ifs.err, ifs.rd_count, ifs.rd_delta} !== pack_s()) begin
            failures++;
            $display("[TB] FAIL rand_s%0d: got %h expected %h", i,
                     {ifs.snap_ack, ifs.ovf, ifs.err, ifs.rd_count, ifs.rd_delta}, pack_s());
         end
      end
      rst = 1'b0;
      idle_inputs();
   endtask

   initial begin
      rst = 1'b1;
      sel = 2'd0;
      idle_inputs();
      test_reset();
      test_wrap_count();
      test_saturate_down();
      test_err();
      test_snapshot_delta();
      test_snap_same_cycle();
      test_back_to_back();
      test_reset_in_ack();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
